mono_frame_scheduler: RTL and testbench
=======================================

// Module: mono_frame_scheduler
// PURPOSE
//  Sequences mono audio samples into fixed-length frames for the spectrum (FFT) stage.
//  Sits between the stereo-to-mono converter (mono_sample_valid/mono_sample) and the FFT AXI-Stream input.
//  Ping-pong buffered: one bank fills while the other drains, one frame per packet with TLAST.
//  Drops and counts samples when both banks are full (overrun).
// PARAMETERS
//  DATA_WIDTH  32   width of mono sample and M_AXIS_TDATA
//  FRAME_LEN   256  samples per frame; power of two, >= 4
//  CNT_WIDTH   16   width of overrun_count (saturating)
//  (local) ADDR_WIDTH = $clog2(FRAME_LEN)
// PORTS
//  ACLK               in   1           clock, all logic on rising edge
//  ARESET             in   1           asynchronous, active-high reset
//  enable             in   1           1 = accept samples; 0 = ignore input, discard partial frame
//  mono_sample_valid  in   1           single-cycle strobe, one sample
//  mono_sample        in   DATA_WIDTH  sample, sampled when mono_sample_valid=1
//  M_AXIS_TVALID      out  1           frame beat valid
//  M_AXIS_TREADY      in   1           downstream ready
//  M_AXIS_TDATA       out  DATA_WIDTH  frame sample, index 0 first
//  M_AXIS_TLAST       out  1           high on beat FRAME_LEN-1 only
//  overrun            out  1           sticky: a sample was dropped since reset
//  overrun_count      out  CNT_WIDTH   dropped samples, saturates at all-ones
//  busy               out  1           any bank full or stream in progress
// BEHAVIOUR
//  Reset (async, ARESET=1): outputs 0; wr_bank=rd_bank=0, wr_ptr=0, bank_full=2'b00, read FSM=RD_IDLE.
//   RAM contents not reset. Reset mid-frame aborts stream; TVALID drops immediately.
//  Write side (per ACLK):
//   enable=0: input ignored (not counted), wr_ptr<=0 (partial frame discarded); full banks kept.
//   enable=1 & valid & !bank_full[wr_bank]: RAM[wr_bank][wr_ptr]<=mono_sample; wr_ptr++.
//    If wr_ptr==FRAME_LEN-1: bank_full[wr_bank]<=1, wr_bank toggles, wr_ptr<=0.
//   enable=1 & valid & bank_full[wr_bank]: sample dropped, overrun<=1, overrun_count++ (saturating).
//  Read FSM (states RD_IDLE, RD_FETCH, RD_SEND):
//   RD_IDLE:  bank_full[rd_bank] -> RD_FETCH, rd_ptr<=0.
//   RD_FETCH: RAM read issued at {rd_bank,rd_ptr} (1-cycle sync read) -> RD_SEND.
//   RD_SEND:  TVALID=1, TDATA=read data, TLAST=(rd_ptr==FRAME_LEN-1).
//    Handshake (TVALID&TREADY): if last -> bank_full[rd_bank]<=0, rd_bank toggles, RD_IDLE;
//    else rd_ptr++, RD_FETCH. No handshake: hold TDATA/TLAST stable, TVALID stays high.
//  Throughput: max one beat per 2 cycles (far above audio rate).
//  Latency: last sample strobed at cycle T -> first beat TVALID at T+3 if read side idle.
//  Ordering: frames emitted in capture order; banks alternate 0,1,0,...
//  Simultaneous set/clear: write sets bank_full[wr_bank] only if clear; read clears only
//   bank_full[rd_bank] when set; both may occur same cycle (on different banks), both take effect.
//  enable deassertion never truncates a frame already full or streaming.
//  busy = |bank_full | (state!=RD_IDLE).
// STRUCTURE
//  Shared package/header: read-FSM state encodings, ADDR_WIDTH derivation.
//  Sub-module frame_bank_ram: simple dual-port RAM, 2*FRAME_LEN x DATA_WIDTH,
//   sync write, registered 1-cycle read, address {bank,ptr}. Controller logic stays in top.
//  Write-side and read-side logic only interact through bank_full.
// TESTING (FRAME_LEN=8, DATA_WIDTH=32)
//  1. enable=1, 8 samples 1..8 every 4 cycles, TREADY=1 -> one packet 1..8, TLAST on 8,
//     first TVALID 3 cycles after sample 8.
//  2. 24 samples 1..24 back-to-back, TREADY=0 until done -> samples 17..24 dropped,
//     overrun=1, overrun_count=8; then TREADY=1 -> packets 1..8, 9..16.
//  3. Random TREADY stalls during stream -> TDATA/TLAST stable while TVALID&!TREADY;
//     data order exact.
//  4. 5 samples, enable=0 for 2 cycles, enable=1, 8 samples 100..107 -> only packet 100..107;
//     overrun_count=0.
//  5. ARESET pulsed mid-stream (beat 3) -> TVALID=0 at once, overrun/count=0;
//     8 new samples -> clean full packet.
//  6. overrun_count at 16'hFFFE plus 3 drops -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/mono_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : mono_frame_scheduler_pkg
// Brief  : Shared read-FSM state encoding and address-width helper.
// Rev    : 1.0
// ============================================================================
package mono_frame_scheduler_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_SEND  = 2'd2
    } rd_state_t;

    function automatic int addr_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_bank_ram.sv
`default_nettype none
// ============================================================================
// Module : frame_bank_ram
// Brief  : Simple dual-port RAM, sync write, registered 1-cycle read.
// Rev    : 1.0
// ============================================================================
module frame_bank_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register only updates on a read request so the output holds during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mono_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module : mono_frame_scheduler
// Brief  : Ping-pong framer of mono samples into AXI-Stream packets with overrun count.
// Rev    : 1.0
// ============================================================================
module mono_frame_scheduler
    import mono_frame_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  enable,
    input  logic                  mono_sample_valid,
    input  logic [DATA_WIDTH-1:0] mono_sample,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    output logic                  overrun,
    output logic [CNT_WIDTH-1:0]  overrun_count,
    output logic                  busy
);

    localparam int ADDR_WIDTH = addr_width(FRAME_LEN);

    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_LAST = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE  = CNT_WIDTH'(1);

    logic                  r_wr_bank;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [1:0]            r_bank_full;
    logic                  r_rd_bank;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic                  r_overrun;
    logic [CNT_WIDTH-1:0]  r_overrun_count;
    rd_state_t             r_state;
    rd_state_t             w_state_nxt;

    logic                  w_wr_accept;
    logic                  w_wr_drop;
    logic                  w_wr_last;
    logic                  w_rd_at_last;
    logic                  w_rd_start;
    logic                  w_rd_issue;
    logic                  w_rd_advance;
    logic                  w_rd_done;
    logic [1:0]            w_set;
    logic [1:0]            w_clr;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_wr_accept  = enable & mono_sample_valid & ~r_bank_full[r_wr_bank];
    assign w_wr_drop    = enable & mono_sample_valid &  r_bank_full[r_wr_bank];
    assign w_wr_last    = w_wr_accept & (r_wr_ptr == c_PTR_LAST);
    assign w_rd_at_last = (r_rd_ptr == c_PTR_LAST);

    // The write side only sets a clear bank and the read side only clears the bank
    // it is draining, so the two masks never target the same bank.
    always_comb begin
        w_set = 2'b00;
        w_clr = 2'b00;
        if (w_wr_last) begin
            w_set[r_wr_bank] = 1'b1;
        end
        if (w_rd_done) begin
            w_clr[r_rd_bank] = 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr_bank       <= 1'b0;
            r_wr_ptr        <= '0;
            r_bank_full     <= 2'b00;
            r_overrun       <= 1'b0;
            r_overrun_count <= '0;
        end else begin
            if (!enable) begin
                r_wr_ptr <= '0;
            end else if (w_wr_accept) begin
                if (w_wr_last) begin
                    r_wr_ptr  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
            end
            if (w_wr_drop) begin
                r_overrun <= 1'b1;
                if (r_overrun_count != '1) begin
                    r_overrun_count <= r_overrun_count + c_CNT_ONE;
                end
            end
            r_bank_full <= (r_bank_full | w_set) & ~w_clr;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        w_rd_start    = 1'b0;
        w_rd_issue    = 1'b0;
        w_rd_advance  = 1'b0;
        w_rd_done     = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_rd_start  = 1'b1;
                    w_state_nxt = RD_FETCH;
                end
            end
            RD_FETCH: begin
                w_rd_issue  = 1'b1;
                w_state_nxt = RD_SEND;
            end
            RD_SEND: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TLAST  = w_rd_at_last;
                if (M_AXIS_TREADY) begin
                    if (w_rd_at_last) begin
                        w_rd_done   = 1'b1;
                        w_state_nxt = RD_IDLE;
                    end else begin
                        w_rd_advance = 1'b1;
                        w_state_nxt  = RD_FETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rd_bank <= 1'b0;
            r_rd_ptr  <= '0;
        end else begin
            if (w_rd_start) begin
                r_rd_ptr <= '0;
            end else if (w_rd_advance) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_rd_done) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    frame_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH + 1)
    ) u_ram (
        .clk     (ACLK),
        .rst     (ARESET),
        .i_we    (w_wr_accept),
        .i_waddr ({r_wr_bank, r_wr_ptr}),
        .i_wdata (mono_sample),
        .i_re    (w_rd_issue),
        .i_raddr ({r_rd_bank, r_rd_ptr}),
        .o_rdata (w_rdata)
    );

    assign M_AXIS_TDATA  = w_rdata;
    assign overrun       = r_overrun;
    assign overrun_count = r_overrun_count;
    assign busy          = (|r_bank_full) | (r_state != RD_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mono_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_mono_frame_scheduler
// Brief  : Directed, table-driven self-checking bench for mono_frame_scheduler.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mono_frame_scheduler;

    localparam int DW = 32;
    localparam int FL = 8;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          en;
    logic          vld;
    logic [DW-1:0] smp;
    logic          tready;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          ovr;
    logic [15:0]   ocnt;
    logic          busy;

    logic          s_en;
    logic          s_vld;
    logic [DW-1:0] s_smp;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic          s_ovr;
    logic [3:0]    s_ocnt;
    logic          s_busy;

    mono_frame_scheduler #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(16)) dut (
        .ACLK              (clk),
        .ARESET            (rst),
        .enable            (en),
        .mono_sample_valid (vld),
        .mono_sample       (smp),
        .M_AXIS_TVALID     (tvalid),
        .M_AXIS_TREADY     (tready),
        .M_AXIS_TDATA      (tdata),
        .M_AXIS_TLAST      (tlast),
        .overrun           (ovr),
        .overrun_count     (ocnt),
        .busy              (busy)
    );

    mono_frame_scheduler #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(4)) dut_sat (
        .ACLK              (clk),
        .ARESET            (rst),
        .enable            (s_en),
        .mono_sample_valid (s_vld),
        .mono_sample       (s_smp),
        .M_AXIS_TVALID     (s_tvalid),
        .M_AXIS_TREADY     (1'b0),
        .M_AXIS_TDATA      (s_tdata),
        .M_AXIS_TLAST      (s_tlast),
        .overrun           (s_ovr),
        .overrun_count     (s_ocnt),
        .busy              (s_busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] din;
        logic          beat;
        logic [DW-1:0] dout;
        logic          last;
    } vec_t;

    vec_t        tbl[$];
    logic [32:0] q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Beat collector plus hold-stability check on stalled beats.
    logic          stalled = 1'b0;
    logic [DW-1:0] held_d;
    logic          held_l;
    always @(negedge clk) begin
        if (tvalid) begin
            if (stalled) begin
                chk("stall_tdata", {32'd0, tdata}, {32'd0, held_d});
                chk("stall_tlast", {63'd0, tlast}, {63'd0, held_l});
            end
            if (tready) begin
                q.push_back({tlast, tdata});
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_d  = tdata;
                held_l  = tlast;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        vld = 1'b1;
        smp = d;
        tick();
        vld = 1'b0;
    endtask

    task automatic build(input int start, input int n, input int nbeats);
        tbl.delete();
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.din  = DW'(start + i);
            v.beat = (i < nbeats);
            v.dout = DW'(start + i);
            v.last = ((i % FL) == FL - 1);
            tbl.push_back(v);
        end
    endtask

    task automatic wait_beats(input string nm, input int n, input int budget);
        int c = 0;
        while (q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(nm, {63'd0, q.size() >= n}, 64'd1);
        tick();
    endtask

    task automatic check_tbl(input string nm);
        int k = 0;
        foreach (tbl[i]) begin
            if (tbl[i].beat) begin
                if (k < q.size()) begin
                    chk({nm, "_data"}, {32'd0, q[k][31:0]}, {32'd0, tbl[i].dout});
                    chk({nm, "_last"}, {63'd0, q[k][32]}, {63'd0, tbl[i].last});
                end else begin
                    chk({nm, "_missing"}, {32'd0, 32'(k)}, {32'd0, 32'(q.size())});
                end
                k++;
            end
        end
        chk({nm, "_count"}, 64'(q.size()), 64'(k));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vld = 1'b0; smp = '0; tready = 1'b1;
        s_en = 1'b0; s_vld = 1'b0; s_smp = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("rst_tlast",  {63'd0, tlast},  64'd0);
        chk("rst_tdata",  {32'd0, tdata},  64'd0);
        chk("rst_ovr",    {63'd0, ovr},    64'd0);
        chk("rst_ocnt",   {48'd0, ocnt},   64'd0);
        chk("rst_busy",   {63'd0, busy},   64'd0);

        // Test 1: spaced samples, latency, single packet.
        en = 1'b1;
        q.delete();
        build(1, FL, FL);
        foreach (tbl[i]) begin
            send(tbl[i].din);
            if (i != FL - 1) repeat (3) tick();
        end
        chk("t1_busy",     {63'd0, busy},   64'd1);
        tick();
        chk("t1_lat_t2",   {63'd0, tvalid}, 64'd0);
        tick();
        chk("t1_lat_t3",   {63'd0, tvalid}, 64'd1);
        chk("t1_first",    {32'd0, tdata},  64'd1);
        wait_beats("t1_timeout", FL, 60);
        check_tbl("t1");
        repeat (3) tick();
        chk("t1_idle",     {63'd0, busy},   64'd0);

        // Test 2: both banks fill, overflow dropped, then drain.
        tready = 1'b0;
        q.delete();
        build(1, 3 * FL, 2 * FL);
        foreach (tbl[i]) send(tbl[i].din);
        tick();
        chk("t2_ovr",    {63'd0, ovr},    64'd1);
        chk("t2_ocnt",   {48'd0, ocnt},   64'd8);
        chk("t2_tvalid", {63'd0, tvalid}, 64'd1);
        chk("t2_tdata",  {32'd0, tdata},  64'd1);
        chk("t2_tlast",  {63'd0, tlast},  64'd0);
        chk("t2_nobeat", 64'(q.size()),   64'd0);
        tready = 1'b1;
        wait_beats("t2_timeout", 2 * FL, 100);
        check_tbl("t2");

        // Test 3: random backpressure.
        q.delete();
        build(200, FL, FL);
        foreach (tbl[i]) begin
            tready = 1'($urandom_range(0, 1));
            send(tbl[i].din);
        end
        for (int c = 0; c < 400 && q.size() < FL; c++) begin
            tready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("t3_timeout", {63'd0, q.size() >= FL}, 64'd1);
        tready = 1'b1;
        check_tbl("t3");
        repeat (3) tick();

        // Test 5: asynchronous reset mid-stream.
        q.delete();
        build(300, FL, FL);
        foreach (tbl[i]) send(tbl[i].din);
        begin
            int c = 0;
            while ((q.size() < 3 || !tvalid) && c < 100) begin
                @(negedge clk);
                c++;
            end
            chk("t5_reach", {63'd0, tvalid}, 64'd1);
        end
        #1 rst = 1'b1;
        #1;
        chk("t5_tvalid", {63'd0, tvalid}, 64'd0);
        chk("t5_ovr",    {63'd0, ovr},    64'd0);
        chk("t5_ocnt",   {48'd0, ocnt},   64'd0);
        chk("t5_busy",   {63'd0, busy},   64'd0);
        tick();
        rst = 1'b0;
        tick();
        q.delete();
        build(400, FL, FL);
        foreach (tbl[i]) send(tbl[i].din);
        wait_beats("t5_timeout", FL, 60);
        check_tbl("t5");
        repeat (3) tick();

        // Test 4: partial frame discarded by enable drop.
        q.delete();
        for (int i = 0; i < 5; i++) send(DW'(50 + i));
        en = 1'b0;
        send(DW'(77));
        tick();
        en = 1'b1;
        build(100, FL, FL);
        foreach (tbl[i]) send(tbl[i].din);
        wait_beats("t4_timeout", FL, 60);
        repeat (20) tick();
        check_tbl("t4");
        chk("t4_ocnt", {48'd0, ocnt}, 64'd0);
        chk("t4_ovr",  {63'd0, ovr},  64'd0);
        chk("t4_busy", {63'd0, busy}, 64'd0);

        // Test 6: overrun counter saturation on a 4-bit counter instance.
        s_en  = 1'b1;
        s_vld = 1'b1;
        for (int i = 0; i < 2 * FL + 14; i++) begin
            s_smp = DW'(1000 + i);
            tick();
        end
        chk("t6_cnt_e",   {60'd0, s_ocnt},   64'hE);
        chk("t6_ovr",     {63'd0, s_ovr},    64'd1);
        chk("t6_tvalid",  {63'd0, s_tvalid}, 64'd1);
        chk("t6_tdata",   {32'd0, s_tdata},  64'd1000);
        chk("t6_tlast",   {63'd0, s_tlast},  64'd0);
        chk("t6_busy",    {63'd0, s_busy},   64'd1);
        repeat (3) tick();
        chk("t6_cnt_sat", {60'd0, s_ocnt},   64'hF);
        s_vld = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
